// File: rtl/a2d_intf.sv
// Two-frame SPI master for an 8-channel 12-bit A2D; latency strt_cnv -> cnv_cmplt = 35*SCLK_DIV+1 cycles.
// Accepts a request only in IDLE; requests arriving mid-conversion are dropped, not queued.
module a2d_intf #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        strt_cnv_i,
  input  logic [2:0]  chnnl_i,
  output logic        cnv_cmplt_o,
  output logic [11:0] res_o,
  output logic        SS_n_o,
  output logic        SCLK_o,
  output logic        MOSI_o,
  input  logic        MISO_i
);

  localparam int CW = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(SCLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          frame_q, frame_d;
  logic [2:0]    chnnl_q, chnnl_d;
  logic [15:0]   tx_q, tx_d;
  logic [11:0]   rx_q, rx_d;
  logic [11:0]   res_q, res_d;
  logic          ss_n_q, ss_n_d;
  logic          sclk_q, sclk_d;
  logic          cmplt_q, cmplt_d;
  logic          meta_q, miso_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    frame_d = frame_q;
    chnnl_d = chnnl_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    res_d   = res_q;
    ss_n_d  = ss_n_q;
    sclk_d  = sclk_q;
    cmplt_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        ss_n_d = 1'b1;
        sclk_d = 1'b1;
        if (strt_cnv_i) begin
          chnnl_d = chnnl_i;
          tx_d    = {2'b00, chnnl_i, 11'b0};
          frame_d = 1'b0;
          ss_n_d  = 1'b0;
          state_d = FRONT;
        end
      end
      FRONT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // bit_q wraps to 0 on the 16th rise, which ends the frame after that high half
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[10:0], miso_q};
            bit_d  = bit_q + 4'd1;
          end else if (bit_q == 4'd0) begin
            state_d = BACK;
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[14:0], 1'b0};
          end
        end
      end
      BACK: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          ss_n_d = 1'b1;
          if (frame_q) begin
            res_d   = rx_q;
            cmplt_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          frame_d = 1'b1;
          tx_d    = {2'b00, chnnl_q, 11'b0};
          ss_n_d  = 1'b0;
          state_d = FRONT;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // rx keeps only 12 bits: the top nibble of each frame shifts out unused
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= 1'b0;
      chnnl_q <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      res_q   <= '0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      cmplt_q <= 1'b0;
      meta_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      chnnl_q <= chnnl_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      res_q   <= res_d;
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
      cmplt_q <= cmplt_d;
      meta_q  <= MISO_i;
      miso_q  <= meta_q;
    end
  end

  assign cnv_cmplt_o = cmplt_q;
  assign res_o       = res_q;
  assign SS_n_o      = ss_n_q;
  assign SCLK_o      = sclk_q;
  assign MOSI_o      = tx_q[15];

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: an A2D slave model plus a bus monitor record each frame; tasks compare against spec timing.
module tb_a2d_intf;
  localparam int DIV   = 32;
  localparam int LAT   = 35 * DIV + 1;
  localparam int FRAME = 17 * DIV;

  logic        clk = 1'b0, rst = 1'b0, strt = 1'b0;
  logic [2:0]  chnnl = 3'd0;
  logic        cmplt, ss_n, sclk, mosi;
  logic [11:0] res;
  logic        miso = 1'b0;
  int          checks = 0, errors = 0, cyc = 0;

  a2d_intf #(.SCLK_DIV(DIV)) dut (
    .clk_i(clk), .rst_i(rst), .strt_cnv_i(strt), .chnnl_i(chnnl),
    .cnv_cmplt_o(cmplt), .res_o(res), .SS_n_o(ss_n), .SCLK_o(sclk),
    .MOSI_o(mosi), .MISO_i(miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A2D model words (frame 0, frame 1) and monitor records per SS_n frame
  logic [15:0] a2d_word [2];
  logic [15:0] mosi_w [4];
  int          rises [4], bad_rise [4], ss_fall [4], ss_len [4];
  int          cm_cyc [4];
  logic [11:0] cm_res [4];
  int          nf = 0, ncm = 0, fcnt = 0, rcnt = 0, epoch = 0, seen = 0;
  logic [15:0] mw = 16'h0;
  logic        ss_p = 1'b1, sclk_p = 1'b1;

  always @(negedge clk) begin
    if (seen != epoch) begin
      seen = epoch; nf = 0; ncm = 0;
      for (int i = 0; i < 4; i++) begin
        rises[i] = 0; bad_rise[i] = 0; mosi_w[i] = 16'h0; ss_len[i] = 0; ss_fall[i] = 0;
      end
    end
    if (ss_p && !ss_n) begin
      if (nf < 4) ss_fall[nf] = cyc;
      fcnt = 0; rcnt = 0; mw = 16'h0;
    end
    if (!ss_p && ss_n && nf < 4) begin
      ss_len[nf] = cyc - ss_fall[nf]; mosi_w[nf] = mw; rises[nf] = rcnt; nf++;
    end
    if (!ss_n && sclk_p && !sclk && fcnt < 16) begin
      miso = a2d_word[nf % 2][15 - fcnt];
      fcnt++;
    end
    if (!ss_n && !sclk_p && sclk) begin
      rcnt++;
      mw = {mw[14:0], mosi};
      if (nf < 4 && (cyc - ss_fall[nf]) != rcnt * DIV) bad_rise[nf]++;
    end
    if (cmplt) begin
      if (ncm < 4) begin cm_cyc[ncm] = cyc; cm_res[ncm] = res; end
      ncm++;
    end
    ss_p = ss_n; sclk_p = sclk;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_conv(input logic [2:0] ch, input logic [15:0] w0, input logic [15:0] w1, output int t0);
    a2d_word[0] = w0; a2d_word[1] = w1;
    epoch++;
    strt = 1'b1; chnnl = ch; t0 = cyc;
    tick();
    strt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n got %b exp 1", ss_n); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b exp 1", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", mosi); end
    checks++; if (cmplt !== 1'b0) begin errors++; $display("FAIL reset_cmplt got %b exp 0", cmplt); end
    checks++; if (res !== 12'h000) begin errors++; $display("FAIL reset_res got %h exp 000", res); end
    rst = 1'b0; tick();
  endtask

  task automatic test_nominal();
    int t0;
    start_conv(3'd5, 16'($urandom), 16'h0ABC, t0);
    repeat (LAT + 20) tick();
    for (int f = 0; f < 2; f++) begin
      checks++; if (mosi_w[f] !== 16'h2800) begin errors++; $display("FAIL nominal_mosi f%0d got %h exp 2800", f, mosi_w[f]); end
      checks++; if (rises[f] != 16) begin errors++; $display("FAIL nominal_rises f%0d got %0d exp 16", f, rises[f]); end
      checks++; if (bad_rise[f] != 0) begin errors++; $display("FAIL nominal_rise_timing f%0d got %0d off-grid exp 0", f, bad_rise[f]); end
      checks++; if (ss_len[f] != FRAME) begin errors++; $display("FAIL nominal_ss_len f%0d got %0d exp %0d", f, ss_len[f], FRAME); end
    end
    checks++; if (ss_fall[0] - t0 != 1) begin errors++; $display("FAIL nominal_ss_fall got %0d exp 1", ss_fall[0] - t0); end
    checks++; if (ss_fall[1] - t0 != FRAME + DIV + 1) begin errors++; $display("FAIL nominal_frame1_fall got %0d exp %0d", ss_fall[1] - t0, FRAME + DIV + 1); end
    checks++; if (ncm != 1) begin errors++; $display("FAIL nominal_cmplt_count got %0d exp 1", ncm); end
    checks++; if (cm_cyc[0] - t0 != LAT) begin errors++; $display("FAIL nominal_latency got %0d exp %0d", cm_cyc[0] - t0, LAT); end
    checks++; if (cm_res[0] !== 12'hABC) begin errors++; $display("FAIL nominal_res got %h exp abc", cm_res[0]); end
  endtask

  task automatic test_mask();
    int t0;
    start_conv(3'($urandom_range(0, 7)), 16'h0FFF, 16'hF123, t0);
    repeat (LAT + 20) tick();
    checks++; if (ncm != 1 || cm_res[0] !== 12'h123) begin errors++; $display("FAIL mask_res got %h (n=%0d) exp 123", cm_res[0], ncm); end
    checks++; if (res !== 12'h123) begin errors++; $display("FAIL mask_res_hold got %h exp 123", res); end
  endtask

  task automatic test_ignored();
    int t0;
    logic [15:0] w1;
    w1 = 16'($urandom);
    start_conv(3'd6, 16'($urandom), w1, t0);
    while (cyc - t0 < LAT + 40) begin
      if (cyc - t0 == 300) begin strt = 1'b1; chnnl = 3'd2; end
      else begin strt = 1'b0; chnnl = 3'd7; end
      tick();
    end
    strt = 1'b0;
    checks++; if (nf != 2) begin errors++; $display("FAIL ignored_frames got %0d exp 2", nf); end
    checks++; if (mosi_w[0] !== 16'h3000 || mosi_w[1] !== 16'h3000) begin errors++; $display("FAIL ignored_mosi got %h/%h exp 3000/3000", mosi_w[0], mosi_w[1]); end
    checks++; if (ncm != 1) begin errors++; $display("FAIL ignored_cmplt_count got %0d exp 1", ncm); end
    checks++; if (cm_res[0] !== w1[11:0]) begin errors++; $display("FAIL ignored_res got %h exp %h", cm_res[0], w1[11:0]); end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [2:0]  ch2;
    logic [15:0] wa, wb;
    wa = 16'($urandom) | 16'h0001; wb = 16'($urandom) | 16'h0002;
    ch2 = 3'($urandom_range(0, 7));
    start_conv(3'd1, 16'h5555, wa, t0);
    while (cyc - t0 < LAT) tick();
    checks++; if (cmplt !== 1'b1) begin errors++; $display("FAIL b2b_done_pulse got %b exp 1", cmplt); end
    strt = 1'b1; chnnl = ch2;
    tick();
    a2d_word[0] = 16'hAAAA; a2d_word[1] = wb;
    tick();
    strt = 1'b0;
    while (cyc - t0 < LAT + 1 + 600) tick();
    checks++; if (res !== wa[11:0]) begin errors++; $display("FAIL b2b_res_hold got %h exp %h", res, wa[11:0]); end
    while (cyc - t0 < 2 * LAT + 40) tick();
    checks++; if (ncm != 2) begin errors++; $display("FAIL b2b_cmplt_count got %0d exp 2", ncm); end
    checks++; if (ss_fall[2] - cm_cyc[0] != 2) begin errors++; $display("FAIL b2b_ss_fall got %0d exp 2 after done", ss_fall[2] - cm_cyc[0]); end
    checks++; if (cm_cyc[1] - cm_cyc[0] != LAT + 1) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", cm_cyc[1] - cm_cyc[0], LAT + 1); end
    checks++; if (cm_res[1] !== wb[11:0]) begin errors++; $display("FAIL b2b_res2 got %h exp %h", cm_res[1], wb[11:0]); end
    checks++; if (mosi_w[3] !== {2'b00, ch2, 11'b0}) begin errors++; $display("FAIL b2b_mosi2 got %h exp %h", mosi_w[3], {2'b00, ch2, 11'b0}); end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [15:0] w1;
    start_conv(3'd3, 16'h1111, 16'h0777, t0);
    while (cyc - t0 < 600) tick();
    checks++; if (ss_n !== 1'b0) begin errors++; $display("FAIL rstmid_active got ss_n=%b exp 0", ss_n); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (ss_n !== 1'b1 || sclk !== 1'b1) begin errors++; $display("FAIL rstmid_pins got ss_n=%b sclk=%b exp 1/1", ss_n, sclk); end
    checks++; if (res !== 12'h000) begin errors++; $display("FAIL rstmid_res got %h exp 000", res); end
    epoch++;
    repeat (LAT + 50) tick();
    checks++; if (ncm != 0) begin errors++; $display("FAIL rstmid_no_cmplt got %0d exp 0", ncm); end
    w1 = 16'($urandom);
    start_conv(3'd4, 16'($urandom), w1, t0);
    repeat (LAT + 20) tick();
    checks++; if (ncm != 1 || cm_cyc[0] - t0 != LAT) begin errors++; $display("FAIL rstmid_restart got n=%0d lat=%0d exp 1/%0d", ncm, cm_cyc[0] - t0, LAT); end
    checks++; if (cm_res[0] !== w1[11:0]) begin errors++; $display("FAIL rstmid_res2 got %h exp %h", cm_res[0], w1[11:0]); end
  endtask

  task automatic test_random();
    int t0;
    logic [2:0]  ch;
    logic [15:0] w1, cmd;
    for (int n = 0; n < 5; n++) begin
      ch = 3'($urandom_range(0, 7)); w1 = 16'($urandom);
      cmd = {2'b00, ch, 11'b0};
      start_conv(ch, 16'($urandom), w1, t0);
      while (cyc - t0 < LAT + 10) begin chnnl = 3'($urandom); tick(); end
      checks++; if (mosi_w[0] !== cmd || mosi_w[1] !== cmd) begin errors++; $display("FAIL random%0d_mosi got %h/%h exp %h", n, mosi_w[0], mosi_w[1], cmd); end
      checks++; if (ncm != 1 || cm_cyc[0] - t0 != LAT) begin errors++; $display("FAIL random%0d_latency got n=%0d lat=%0d exp 1/%0d", n, ncm, cm_cyc[0] - t0, LAT); end
      checks++; if (cm_res[0] !== w1[11:0]) begin errors++; $display("FAIL random%0d_res got %h exp %h", n, cm_res[0], w1[11:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mask();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
